// File: rtl/thread_scheduler_if.sv
// Launch, issue and writeback signals between the compute core and the thread scheduler.
// Issue handshake: an offer transfers on any rising edge where issue_valid and issue_ready are both 1.
// While issue_valid=1 and issue_ready=0, issue_tid and issue_pc stay stable.
interface thread_scheduler_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8,
  parameter int TID_WIDTH   = 2
);
  logic                            start;
  logic [TID_WIDTH:0]              thread_count;
  logic [PC_WIDTH-1:0]             start_pc;
  logic                            issue_valid;
  logic                            issue_ready;
  logic [TID_WIDTH-1:0]            issue_tid;
  logic [PC_WIDTH-1:0]             issue_pc;
  logic                            wb_valid;
  logic [TID_WIDTH-1:0]            wb_tid;
  logic                            wb_halt;
  logic                            wb_branch;
  logic [PC_WIDTH-1:0]             wb_target;
  logic                            busy;
  logic                            done;
  logic                            halt;
  logic                            protocol_err;
  logic [NUM_THREADS*PC_WIDTH-1:0] pc_flat;
  logic [1:0]                      dbg_state;

  modport master (
    output start, thread_count, start_pc, issue_ready,
    output wb_valid, wb_tid, wb_halt, wb_branch, wb_target,
    input  issue_valid, issue_tid, issue_pc, busy, done, halt, protocol_err, pc_flat, dbg_state
  );

  modport slave (
    input  start, thread_count, start_pc, issue_ready,
    input  wb_valid, wb_tid, wb_halt, wb_branch, wb_target,
    output issue_valid, issue_tid, issue_pc, busy, done, halt, protocol_err, pc_flat, dbg_state
  );
endinterface

// File: rtl/thread_scheduler.sv
// Per-thread PC and round-robin issue scheduler: launches threads at a common PC,
// offers one READY thread per cycle, and updates PCs from execute writeback.
module thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 8,
  parameter int TID_WIDTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  thread_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {T_OFF, T_READY, T_WAIT, T_HALTED} tstate_e;

  state_e               r_state, w_state_n;
  tstate_e              r_tstate   [NUM_THREADS];
  tstate_e              w_tstate_n [NUM_THREADS];
  logic [PC_WIDTH-1:0]  r_pc       [NUM_THREADS];
  logic [PC_WIDTH-1:0]  w_pc_n     [NUM_THREADS];
  logic [TID_WIDTH-1:0] r_ptr, w_ptr_n;
  logic                 r_offer_valid, w_offer_valid_n;
  logic [TID_WIDTH-1:0] r_offer_tid, w_offer_tid_n;
  logic [PC_WIDTH-1:0]  r_offer_pc, w_offer_pc_n;
  logic                 r_done, w_done_n;
  logic                 r_err, w_err_n;
  logic                 w_accept, w_start_ok, w_wb_legal, w_found, w_active;
  logic [TID_WIDTH:0]   w_count;
  int                   w_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_tstate[i] <= T_OFF;
        r_pc[i]     <= '0;
      end
      r_ptr         <= '0;
      r_offer_valid <= 1'b0;
      r_offer_tid   <= '0;
      r_offer_pc    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_tstate      <= w_tstate_n;
      r_pc          <= w_pc_n;
      r_ptr         <= w_ptr_n;
      r_offer_valid <= w_offer_valid_n;
      r_offer_tid   <= w_offer_tid_n;
      r_offer_pc    <= w_offer_pc_n;
      r_done        <= w_done_n;
      r_err         <= w_err_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_tstate_n      = r_tstate;
    w_pc_n          = r_pc;
    w_ptr_n         = r_ptr;
    w_offer_valid_n = r_offer_valid;
    w_offer_tid_n   = r_offer_tid;
    w_offer_pc_n    = r_offer_pc;
    w_done_n        = 1'b0;
    w_err_n         = r_err;
    w_found         = 1'b0;
    w_active        = 1'b0;
    w_idx           = 0;
    w_accept        = r_offer_valid & bus.issue_ready;
    w_start_ok      = bus.start & (r_state != S_RUN);
    w_count         = (int'(bus.thread_count) > NUM_THREADS) ?
                      (TID_WIDTH+1)'(NUM_THREADS) : bus.thread_count;
    // The offered thread is still READY, so a writeback racing its accept is illegal here.
    w_wb_legal      = bus.wb_valid && (int'(bus.wb_tid) < NUM_THREADS) &&
                      (r_tstate[bus.wb_tid] == T_WAIT);

    if (w_start_ok) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (i < int'(w_count)) begin
          w_tstate_n[i] = T_READY;
          w_pc_n[i]     = bus.start_pc;
        end else begin
          w_tstate_n[i] = T_OFF;
        end
      end
      w_ptr_n         = '0;
      w_err_n         = 1'b0;
      w_offer_valid_n = 1'b0;
      if (w_count == '0) begin
        w_state_n = S_DONE;
        w_done_n  = 1'b1;
      end else begin
        w_state_n = S_RUN;
      end
    end else begin
      if (w_accept) begin
        w_tstate_n[r_offer_tid] = T_WAIT;
        w_ptr_n = (int'(r_offer_tid) == NUM_THREADS - 1) ? '0 : r_offer_tid + 1'b1;
      end

      if (bus.wb_valid) begin
        if (w_wb_legal) begin
          if (bus.wb_halt) begin
            w_tstate_n[bus.wb_tid] = T_HALTED;
          end else if (bus.wb_branch) begin
            w_tstate_n[bus.wb_tid] = T_READY;
            w_pc_n[bus.wb_tid]     = bus.wb_target;
          end else begin
            w_tstate_n[bus.wb_tid] = T_READY;
            w_pc_n[bus.wb_tid]     = r_pc[bus.wb_tid] + 1'b1;
          end
        end else begin
          w_err_n = 1'b1;
        end
      end

      // Selection sees only threads READY before this edge; w_ptr_n already points past an accept.
      if ((r_state == S_RUN) && (!r_offer_valid || w_accept)) begin
        w_offer_valid_n = 1'b0;
        for (int j = 0; j < NUM_THREADS; j++) begin
          w_idx = (int'(w_ptr_n) + j) % NUM_THREADS;
          if (!w_found && (r_tstate[TID_WIDTH'(w_idx)] == T_READY) &&
              !(w_accept && (w_idx == int'(r_offer_tid)))) begin
            w_found         = 1'b1;
            w_offer_valid_n = 1'b1;
            w_offer_tid_n   = TID_WIDTH'(w_idx);
            w_offer_pc_n    = r_pc[TID_WIDTH'(w_idx)];
          end
        end
      end

      if (r_state == S_RUN) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          if ((w_tstate_n[i] == T_READY) || (w_tstate_n[i] == T_WAIT)) w_active = 1'b1;
        end
        if (!w_active) begin
          w_state_n       = S_DONE;
          w_done_n        = 1'b1;
          w_offer_valid_n = 1'b0;
        end
      end
    end
  end

  assign bus.issue_valid  = r_offer_valid;
  assign bus.issue_tid    = r_offer_tid;
  assign bus.issue_pc     = r_offer_pc;
  assign bus.busy         = (r_state == S_RUN);
  assign bus.done         = r_done;
  assign bus.halt         = (r_state == S_DONE);
  assign bus.protocol_err = r_err;
  assign bus.dbg_state    = r_state;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_pc_flat
    assign bus.pc_flat[g*PC_WIDTH +: PC_WIDTH] = r_pc[g];
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: launch, round-robin issue, writeback, backpressure,
// completion, protocol errors and asynchronous reset.
module tb_thread_scheduler;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [14:0] exp_s;

  thread_scheduler_if #(.NUM_THREADS(4), .PC_WIDTH(8), .TID_WIDTH(2)) bus ();

  thread_scheduler #(.NUM_THREADS(4), .PC_WIDTH(8), .TID_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {issue_valid, issue_tid, issue_pc, busy, done, halt, protocol_err}
  function automatic logic [14:0] st();
    return {bus.issue_valid, bus.issue_tid, bus.issue_pc, bus.busy, bus.done, bus.halt, bus.protocol_err};
  endfunction

  function automatic logic [14:0] ex(input logic v, input logic [1:0] t, input logic [7:0] p,
                                     input logic b, input logic d, input logic h, input logic e);
    return {v, t, p, b, d, h, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] cnt, input logic [7:0] pc);
    bus.start        = 1'b1;
    bus.thread_count = cnt;
    bus.start_pc     = pc;
    step();
    bus.start        = 1'b0;
  endtask

  task automatic wb(input logic [1:0] tid, input logic h, input logic b, input logic [7:0] tgt);
    bus.wb_valid  = 1'b1;
    bus.wb_tid    = tid;
    bus.wb_halt   = h;
    bus.wb_branch = b;
    bus.wb_target = tgt;
  endtask

  task automatic wb_off();
    bus.wb_valid  = 1'b0;
    bus.wb_halt   = 1'b0;
    bus.wb_branch = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    exp_s = ex(0, 0, 8'h00, 0, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL reset_status got %h exp %h", st(), exp_s); else n_pass++;
    n_checks++;
    if (bus.pc_flat !== 32'h0) $display("FAIL reset_pcs got %h exp %h", bus.pc_flat, 32'h0); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_launch_issue();
    bus.issue_ready = 1'b1;
    launch(3'd4, 8'h10);
    exp_s = ex(0, 0, 8'h00, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL launch_status got %h exp %h", st(), exp_s); else n_pass++;
    n_checks++;
    if (bus.pc_flat !== 32'h10101010) $display("FAIL launch_pcs got %h exp %h", bus.pc_flat, 32'h10101010); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_s = ex(1, 2'(k), 8'h10, 1, 0, 0, 0);
      n_checks++;
      if (st() !== exp_s) $display("FAIL issue_seq%0d got %h exp %h", k, st(), exp_s); else n_pass++;
    end
    step();
    n_checks++;
    if ({bus.issue_valid, bus.busy} !== 2'b01) $display("FAIL issue_drain got %b exp %b", {bus.issue_valid, bus.busy}, 2'b01); else n_pass++;
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_writeback();
    wb(2'd1, 0, 0, 8'h00);
    step();
    wb_off();
    n_checks++;
    if (bus.pc_flat[15:8] !== 8'h11) $display("FAIL wb_seq_pc1 got %h exp %h", bus.pc_flat[15:8], 8'h11); else n_pass++;
    step();
    exp_s = ex(1, 1, 8'h11, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL wb_reoffer1 got %h exp %h", st(), exp_s); else n_pass++;
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
    wb(2'd2, 0, 1, 8'h40);
    step();
    n_checks++;
    if (bus.pc_flat[23:16] !== 8'h40) $display("FAIL wb_branch_pc2 got %h exp %h", bus.pc_flat[23:16], 8'h40); else n_pass++;
    wb(2'd3, 0, 1, 8'hFF);
    step();
    wb_off();
    exp_s = ex(1, 2, 8'h40, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL wb_offer2 got %h exp %h", st(), exp_s); else n_pass++;
    bus.issue_ready = 1'b1;
    step();
    exp_s = ex(1, 3, 8'hFF, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL wb_offer3 got %h exp %h", st(), exp_s); else n_pass++;
    step();
    bus.issue_ready = 1'b0;
    n_checks++;
    if (bus.issue_valid !== 1'b0) $display("FAIL wb_drain got %b exp %b", bus.issue_valid, 1'b0); else n_pass++;
    wb(2'd3, 0, 0, 8'h00);
    step();
    wb_off();
    n_checks++;
    if ({bus.pc_flat[31:24], bus.protocol_err} !== {8'h00, 1'b0}) $display("FAIL wb_wrap_pc3 got %h exp %h", {bus.pc_flat[31:24], bus.protocol_err}, {8'h00, 1'b0}); else n_pass++;
  endtask

  task automatic test_backpressure();
    step();
    exp_s = ex(1, 3, 8'h00, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL bp_offer got %h exp %h", st(), exp_s); else n_pass++;
    wb(2'd0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      wb_off();
      n_checks++;
      if (st() !== exp_s) $display("FAIL bp_hold%0d got %h exp %h", k, st(), exp_s); else n_pass++;
    end
    n_checks++;
    if (bus.pc_flat[7:0] !== 8'h11) $display("FAIL bp_pc0 got %h exp %h", bus.pc_flat[7:0], 8'h11); else n_pass++;
    bus.issue_ready = 1'b1;
    step();
    exp_s = ex(1, 0, 8'h11, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL bp_next got %h exp %h", st(), exp_s); else n_pass++;
    step();
    bus.issue_ready = 1'b0;
    n_checks++;
    if (bus.issue_valid !== 1'b0) $display("FAIL bp_drain got %b exp %b", bus.issue_valid, 1'b0); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    wb(2'd1, 0, 0, 8'h00);
    step();
    wb_off();
    step();
    exp_s = ex(1, 1, 8'h12, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL mid_offer got %h exp %h", st(), exp_s); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    exp_s = ex(0, 0, 8'h00, 0, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL mid_reset_status got %h exp %h", st(), exp_s); else n_pass++;
    n_checks++;
    if ({bus.pc_flat, bus.dbg_state} !== 34'h0) $display("FAIL mid_reset_state got %h exp %h", {bus.pc_flat, bus.dbg_state}, 34'h0); else n_pass++;
    step();
    reset = 1'b1;
  endtask

  task automatic test_partial_halt();
    bus.issue_ready = 1'b1;
    launch(3'd2, 8'h20);
    n_checks++;
    if (bus.pc_flat !== 32'h00002020) $display("FAIL part_pcs got %h exp %h", bus.pc_flat, 32'h00002020); else n_pass++;
    step();
    exp_s = ex(1, 0, 8'h20, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL part_offer0 got %h exp %h", st(), exp_s); else n_pass++;
    step();
    exp_s = ex(1, 1, 8'h20, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL part_offer1 got %h exp %h", st(), exp_s); else n_pass++;
    step();
    bus.issue_ready = 1'b0;
    n_checks++;
    if (bus.issue_valid !== 1'b0) $display("FAIL part_drain got %b exp %b", bus.issue_valid, 1'b0); else n_pass++;
    wb(2'd0, 1, 1, 8'h99);
    step();
    n_checks++;
    if ({bus.busy, bus.done, bus.halt, bus.protocol_err, bus.pc_flat[7:0]} !== {4'b1000, 8'h20}) $display("FAIL part_halt0 got %h exp %h", {bus.busy, bus.done, bus.halt, bus.protocol_err, bus.pc_flat[7:0]}, {4'b1000, 8'h20}); else n_pass++;
    wb(2'd1, 1, 0, 8'h00);
    step();
    wb_off();
    n_checks++;
    if ({bus.issue_valid, bus.busy, bus.done, bus.halt, bus.protocol_err} !== 5'b00110) $display("FAIL part_done got %b exp %b", {bus.issue_valid, bus.busy, bus.done, bus.halt, bus.protocol_err}, 5'b00110); else n_pass++;
    step();
    n_checks++;
    if ({bus.busy, bus.done, bus.halt, bus.protocol_err, bus.dbg_state} !== 6'b001010) $display("FAIL part_after got %b exp %b", {bus.busy, bus.done, bus.halt, bus.protocol_err, bus.dbg_state}, 6'b001010); else n_pass++;
    n_checks++;
    if (bus.pc_flat[31:16] !== 16'h0) $display("FAIL part_off_pcs got %h exp %h", bus.pc_flat[31:16], 16'h0); else n_pass++;
  endtask

  task automatic test_errors();
    wb(2'd3, 0, 0, 8'h00);
    step();
    wb_off();
    n_checks++;
    if ({bus.busy, bus.done, bus.halt, bus.protocol_err} !== 4'b0011) $display("FAIL err_set got %b exp %b", {bus.busy, bus.done, bus.halt, bus.protocol_err}, 4'b0011); else n_pass++;
    step();
    n_checks++;
    if (bus.protocol_err !== 1'b1) $display("FAIL err_sticky got %b exp %b", bus.protocol_err, 1'b1); else n_pass++;
    launch(3'd0, 8'h33);
    n_checks++;
    if ({bus.issue_valid, bus.busy, bus.done, bus.halt, bus.protocol_err} !== 5'b00110) $display("FAIL zero_start got %b exp %b", {bus.issue_valid, bus.busy, bus.done, bus.halt, bus.protocol_err}, 5'b00110); else n_pass++;
    step();
    n_checks++;
    if ({bus.busy, bus.done, bus.halt, bus.protocol_err} !== 4'b0010) $display("FAIL zero_after got %b exp %b", {bus.busy, bus.done, bus.halt, bus.protocol_err}, 4'b0010); else n_pass++;
  endtask

  task automatic test_clamp_and_races();
    launch(3'd7, 8'h50);
    n_checks++;
    if (bus.pc_flat !== 32'h50505050) $display("FAIL clamp_pcs got %h exp %h", bus.pc_flat, 32'h50505050); else n_pass++;
    bus.start        = 1'b1;
    bus.thread_count = 3'd1;
    bus.start_pc     = 8'h60;
    step();
    bus.start        = 1'b0;
    n_checks++;
    if (bus.pc_flat !== 32'h50505050) $display("FAIL run_start_ignored got %h exp %h", bus.pc_flat, 32'h50505050); else n_pass++;
    exp_s = ex(1, 0, 8'h50, 1, 0, 0, 0);
    n_checks++;
    if (st() !== exp_s) $display("FAIL clamp_offer0 got %h exp %h", st(), exp_s); else n_pass++;
    bus.issue_ready = 1'b1;
    wb(2'd0, 0, 0, 8'h00);
    step();
    exp_s = ex(1, 1, 8'h50, 1, 0, 0, 1);
    n_checks++;
    if ({st(), bus.pc_flat[7:0]} !== {exp_s, 8'h50}) $display("FAIL same_tid_race got %h exp %h", {st(), bus.pc_flat[7:0]}, {exp_s, 8'h50}); else n_pass++;
    wb(2'd0, 0, 1, 8'h70);
    step();
    wb_off();
    bus.issue_ready = 1'b0;
    exp_s = ex(1, 2, 8'h50, 1, 0, 0, 1);
    n_checks++;
    if ({st(), bus.pc_flat[7:0]} !== {exp_s, 8'h70}) $display("FAIL diff_tid_race got %h exp %h", {st(), bus.pc_flat[7:0]}, {exp_s, 8'h70}); else n_pass++;
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.thread_count = '0;
    bus.start_pc     = '0;
    bus.issue_ready  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_tid       = '0;
    bus.wb_halt      = 1'b0;
    bus.wb_branch    = 1'b0;
    bus.wb_target    = '0;
    test_reset();
    test_launch_issue();
    test_writeback();
    test_backpressure();
    test_reset_midrun();
    test_partial_halt();
    test_errors();
    test_clamp_and_races();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Parametrised per-thread PC and scheduling unit for the compute core; successor to the fixed 4-thread PC array.
- Launches up to NUM_THREADS threads at a common start PC and offers one ready thread per cycle to the issue stage over a valid/ready handshake.
- Updates each thread's PC from execute-stage writeback (sequential step, branch or halt).
- Raises halt when every launched thread has halted.

Parameters:
- NUM_THREADS, 4, number of hardware threads (1..16).
- PC_WIDTH, 8, width of each thread PC.
- TID_WIDTH, 2, thread-id width; must equal max(1, ceil(log2(NUM_THREADS))).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  launch request; honoured only in IDLE or DONE.
- thread_count  in  TID_WIDTH+1  number of threads to launch (0..NUM_THREADS).
- start_pc  in  PC_WIDTH  initial PC for all launched threads.
- issue_valid  out  1  a thread is offered for issue.
- issue_ready  in  1  issue stage accepts the offer.
- issue_tid  out  TID_WIDTH  offered thread id.
- issue_pc  out  PC_WIDTH  PC of the offered thread.
- wb_valid  in  1  writeback event for wb_tid.
- wb_tid  in  TID_WIDTH  thread completing its instruction.
- wb_halt  in  1  thread executed HALT.
- wb_branch  in  1  branch taken.
- wb_target  in  PC_WIDTH  branch target.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- halt  out  1  high while in DONE.
- protocol_err  out  1  sticky error flag; cleared by an accepted start.
- pc_flat  out  NUM_THREADS*PC_WIDTH  all thread PCs, thread i at bits [i*PC_WIDTH +: PC_WIDTH].

Behaviour:
- Reset (reset=0, asynchronous):
  - Global FSM=IDLE; all threads OFF; all PCs 0; round-robin pointer 0.
  - Outputs: issue_valid=0, issue_tid=0, issue_pc=0, busy=0, done=0, halt=0, protocol_err=0.
  - Reset mid-run abandons all state immediately.
- Global FSM:
  - IDLE --start--> RUN.
  - RUN --all launched threads HALTED--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
- Launch (start accepted):
  - Threads i < thread_count: PC=start_pc, state READY.
  - All other threads: OFF.
  - Round-robin pointer resets to 0; protocol_err cleared.
  - thread_count=0: FSM goes straight to DONE, with done pulsing the next cycle.
  - thread_count > NUM_THREADS is clamped to NUM_THREADS.
- Per-thread states: OFF, READY, WAIT, HALTED.
- Issue selection:
  - In RUN with no offer pending, select the first READY thread scanning from the pointer upward with wrap-around.
  - Register the selection as the offer; issue_valid rises the cycle after the thread becomes READY.
- Offer stability: while issue_valid=1 and issue_ready=0, issue_tid and issue_pc hold stable, regardless of other writebacks.
- Accept (issue_valid & issue_ready at an edge):
  - Offered thread moves to WAIT.
  - Pointer becomes (tid+1) mod NUM_THREADS.
  - A new offer may be presented in the same cycle (back-to-back issue of distinct threads).
- Writeback (wb_valid, thread in WAIT):
  - wb_halt=1 → HALTED; PC unchanged. wb_halt has priority over wb_branch.
  - else wb_branch=1 → PC=wb_target, READY.
  - else → PC=PC+1 modulo 2^PC_WIDTH (0xFF→0x00 at width 8), READY.
- Writeback to a thread not in WAIT: no state change; protocol_err set. Same for wb_tid ≥ NUM_THREADS.
- Simultaneous events:
  - Accept and writeback in one cycle to different threads both take effect.
  - Accept and writeback to the same thread cannot both be legal; the writeback is flagged as an error and the accept still applies.
- Completion:
  - When the last launched thread reaches HALTED, FSM enters DONE on that edge.
  - done=1 for exactly the following cycle; halt=1 until the next start is accepted.
  - issue_valid=0 in DONE.

Test Plan:
- Reset with outputs driven: reset=0 mid-RUN → all outputs, PCs and FSM at reset values within the same cycle, not waiting for a clock edge.
- Launch count=4, start_pc=0x10, issue_ready=1, no writebacks → issue_tid sequence 0,1,2,3, each issue_pc=0x10, then issue_valid=0.
- Writebacks after issue:
  - tid1 sequential → pc1=0x11 and tid1 re-offered.
  - tid2 branch to 0x40 → pc2=0x40.
  - tid3 at PC 0xFF sequential → 0x00.
- Backpressure: hold issue_ready=0 for 5 cycles while writing back another thread → issue_tid/issue_pc unchanged; accepted on ready.
- Partial launch count=2, halt tid0 then tid1 → done pulses one cycle after the second halt, halt stays 1, busy=0; threads 2..3 remain OFF.
- Error cases:
  - Writeback to tid3 when OFF → protocol_err=1 and sticky; next start clears it.
  - start with count=0 → done pulses, halt=1.
